// File: rtl/matrix_bank_loader.sv
// matrix_bank_loader
//   Loads 5x7 pixel rows into one of four display banks through a staging
//   buffer. A bank is only overwritten, atomically, once all seven rows have
//   arrived in order. A dwell counter can rotate the displayed bank.
//
// Optional feature macro: MATRIX_BANK_LOADER_ROTATE_EN
//   defined   -> ROTATE=1 auto-rotates banks every DWELL_CYCLES clocks
//   undefined -> ROTATE ignored, displayed bank always follows MAN_SEL
//
// Ports
//   CLK, RST_N          clock, asynchronous active-low reset
//   WR_VALID/WR_READY   row write handshake
//   WR_BANK             target bank (sampled with row 0)
//   WR_ROW, WR_DATA     row index 0..6 and its 5 pixels (bit c = column c)
//   ROTATE, MAN_SEL     auto-rotate enable, manual bank select
//   FRAME_OUT           all banks, bit bank*35 + row*5 + col
//   SEL0, SEL1          displayed bank = 2*SEL0 + SEL1
//   DONE, ERR           one-cycle pulses: commit finished / load aborted
module matrix_bank_loader #(
  parameter int unsigned DWELL_CYCLES = 1000
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         WR_VALID,
  output logic         WR_READY,
  input  logic [1:0]   WR_BANK,
  input  logic [2:0]   WR_ROW,
  input  logic [4:0]   WR_DATA,
  input  logic         ROTATE,
  input  logic [1:0]   MAN_SEL,
  output logic [139:0] FRAME_OUT,
  output logic         SEL0,
  output logic         SEL1,
  output logic         DONE,
  output logic         ERR
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMMIT} state_e;

  state_e       state_q, state_d;
  logic [34:0]  stage_q, stage_d;
  logic [1:0]   bank_q, bank_d;
  logic [2:0]   exp_row_q, exp_row_d;
  logic [139:0] frame_q, frame_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic [1:0]   sel_q, sel_d;
  logic         accept;
  logic [34:0]  row_ins;

  assign accept = WR_VALID && WR_READY;

  // Staging buffer with the offered row merged in at WR_ROW.
  always_comb begin
    row_ins = stage_q;
    case (WR_ROW)
      3'd0:    row_ins[4:0]   = WR_DATA;
      3'd1:    row_ins[9:5]   = WR_DATA;
      3'd2:    row_ins[14:10] = WR_DATA;
      3'd3:    row_ins[19:15] = WR_DATA;
      3'd4:    row_ins[24:20] = WR_DATA;
      3'd5:    row_ins[29:25] = WR_DATA;
      3'd6:    row_ins[34:30] = WR_DATA;
      default: row_ins = stage_q;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and load-path logic
  always_comb begin
    state_d   = state_q;
    stage_d   = stage_q;
    bank_d    = bank_q;
    exp_row_d = exp_row_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WR_ROW == 3'd0) begin
            state_d   = S_LOAD;
            bank_d    = WR_BANK;
            exp_row_d = 3'd1;
            stage_d   = {30'b0, WR_DATA};
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          if (WR_ROW == 3'd0) begin
            // Row 0 restarts silently, possibly retargeting another bank.
            bank_d    = WR_BANK;
            exp_row_d = 3'd1;
            stage_d   = {30'b0, WR_DATA};
          end else if (WR_ROW == exp_row_q) begin
            stage_d   = row_ins;
            exp_row_d = exp_row_q + 3'd1;
            if (WR_ROW == 3'd6) begin
              state_d = S_COMMIT;
              done_d  = 1'b1;  // registered, so DONE is high during COMMIT
            end
          end else begin
            state_d = S_IDLE;
            stage_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      S_COMMIT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    WR_READY = (state_q != S_COMMIT);
  end

  // Banks live directly in the output register; only COMMIT touches them.
  always_comb begin
    frame_d = frame_q;
    if (state_q == S_COMMIT) begin
      case (bank_q)
        2'd0: frame_d[34:0]    = stage_q;
        2'd1: frame_d[69:35]   = stage_q;
        2'd2: frame_d[104:70]  = stage_q;
        2'd3: frame_d[139:105] = stage_q;
        default: frame_d = frame_q;
      endcase
    end
  end

`ifdef MATRIX_BANK_LOADER_ROTATE_EN
  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);

  logic [15:0] dwell_q, dwell_d;

  // Counter is pinned at 0 while manual, so rotation starts a full dwell
  // on whatever bank is already displayed.
  always_comb begin
    dwell_d = '0;
    sel_d   = MAN_SEL;
    if (ROTATE) begin
      sel_d = sel_q;
      if (dwell_q == DWELL_LAST) begin
        dwell_d = '0;
        sel_d   = sel_q + 2'd1;
      end else begin
        dwell_d = dwell_q + 16'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) dwell_q <= '0;
    else        dwell_q <= dwell_d;
  end
`else
  logic unused_rotate;
  assign unused_rotate = ROTATE ^ (DWELL_CYCLES > 0);

  always_comb begin
    sel_d = MAN_SEL;
  end
`endif

  // Datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      stage_q   <= '0;
      bank_q    <= '0;
      exp_row_q <= '0;
      frame_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sel_q     <= '0;
    end else begin
      stage_q   <= stage_d;
      bank_q    <= bank_d;
      exp_row_q <= exp_row_d;
      frame_q   <= frame_d;
      done_q    <= done_d;
      err_q     <= err_d;
      sel_q     <= sel_d;
    end
  end

  assign FRAME_OUT = frame_q;
  assign SEL0      = sel_q[1];
  assign SEL1      = sel_q[0];
  assign DONE      = done_q;
  assign ERR       = err_q;

endmodule
